// File: rtl/flag_cond_unit.sv
// Flag and condition unit for a two-stage ARM-like pipeline.
// Tracks flag-setting instructions that are in flight, stalls ID when its
// condition would read stale flags, forwards EXE flags when exactly one
// writer is outstanding, and registers the issue/condition result into EXE.
module flag_cond_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [3:0] id_cond,
    input  logic       id_s,
    input  logic       flush,
    input  logic       flag_we,
    input  logic [3:0] status_in,
    output logic [3:0] status_q,
    output logic       carry_q,
    output logic       id_stall,
    output logic       id_cond_pass,
    output logic       exe_valid_q,
    output logic       exe_cond_pass_q
);

    // Outstanding flag writers that have issued but not yet written (0..3).
    logic [1:0] count_q;
    logic [1:0] count_next;
    logic [3:0] eval_flags;
    logic       needs_flags;
    logic       hazard;
    logic       issue;

    // Evaluate an ARM condition field against flags ordered {N,Z,C,V}.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        n = flags[3];
        z = flags[2];
        c = flags[1];
        v = flags[0];
        case (cond)
            4'b0000: cond_eval = z;
            4'b0001: cond_eval = !z;
            4'b0010: cond_eval = c;
            4'b0011: cond_eval = !c;
            4'b0100: cond_eval = n;
            4'b0101: cond_eval = !n;
            4'b0110: cond_eval = v;
            4'b0111: cond_eval = !v;
            4'b1000: cond_eval = c & !z;
            4'b1001: cond_eval = !c | z;
            4'b1010: cond_eval = (n == v);
            4'b1011: cond_eval = (n != v);
            4'b1100: cond_eval = !z & (n == v);
            4'b1101: cond_eval = z | (n != v);
            default: cond_eval = 1'b1;
        endcase
    endfunction

    // Hazard detection, flag forwarding, stall and issue decisions.
    always_comb begin
        needs_flags  = (id_cond[3:1] != 3'b111);
        hazard       = (count_q >= 2'd2) || ((count_q == 2'd1) && !flag_we);
        // With one writer outstanding and it writing now, its flags are the
        // ones the ID instruction must see.
        eval_flags   = (flag_we && (count_q == 2'd1)) ? status_in : status_q;
        id_stall     = id_valid && !flush &&
                       ((needs_flags && hazard) ||
                        (id_s && (count_q == 2'd3) && !flag_we));
        issue        = id_valid && !id_stall && !flush;
        id_cond_pass = cond_eval(id_cond, eval_flags);
    end

    // Next pending count: issue of an S instruction adds, a flag write retires.
    always_comb begin
        count_next = count_q;
        if (flush) begin
            count_next = 2'd0;
        end else begin
            if (issue && id_s) begin
                count_next = count_next + 2'd1;
            end
            if (flag_we && (count_q != 2'd0)) begin
                count_next = count_next - 2'd1;
            end
        end
    end

    // Architectural flags, pending counter and EXE issue registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q        <= 4'b0000;
            count_q         <= 2'd0;
            exe_valid_q     <= 1'b0;
            exe_cond_pass_q <= 1'b0;
        end else begin
            if (flag_we) begin
                status_q <= status_in;
            end
            count_q         <= count_next;
            exe_valid_q     <= issue;
            exe_cond_pass_q <= issue && id_cond_pass;
        end
    end

    assign carry_q = status_q[1];

endmodule

// File: tb/tb_flag_cond_unit.sv
// Directed testbench for flag_cond_unit.
module tb_flag_cond_unit;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [3:0] id_cond;
    logic       id_s;
    logic       flush;
    logic       flag_we;
    logic [3:0] status_in;
    logic [3:0] status_q;
    logic       carry_q;
    logic       id_stall;
    logic       id_cond_pass;
    logic       exe_valid_q;
    logic       exe_cond_pass_q;

    int checks = 0;
    int errors = 0;

    flag_cond_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_cond(id_cond), .id_s(id_s),
        .flush(flush), .flag_we(flag_we), .status_in(status_in), .status_q(status_q),
        .carry_q(carry_q), .id_stall(id_stall), .id_cond_pass(id_cond_pass),
        .exe_valid_q(exe_valid_q), .exe_cond_pass_q(exe_cond_pass_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid  = 1'b0;
        id_cond   = 4'b1110;
        id_s      = 1'b0;
        flush     = 1'b0;
        flag_we   = 1'b0;
        status_in = 4'b0000;
    endtask

    // Issue one S instruction with AL condition (no flag write).
    task automatic issue_s_al();
        idle();
        id_valid = 1'b1;
        id_s     = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (status_q !== 4'b0000) begin errors++; $display("FAIL reset_status got %b exp 0000", status_q); end
        checks++; if (carry_q !== 1'b0) begin errors++; $display("FAIL reset_carry got %b exp 0", carry_q); end
        checks++; if (exe_valid_q !== 1'b0) begin errors++; $display("FAIL reset_exe_valid got %b exp 0", exe_valid_q); end
        checks++; if (exe_cond_pass_q !== 1'b0) begin errors++; $display("FAIL reset_exe_pass got %b exp 0", exe_cond_pass_q); end
        rst = 1'b0;
        // First instruction after reset: EQ with Z=0
        id_valid = 1'b1;
        id_cond  = 4'b0000;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL first_eq_stall got %b exp 0", id_stall); end
        checks++; if (id_cond_pass !== 1'b0) begin errors++; $display("FAIL first_eq_pass got %b exp 0", id_cond_pass); end
        tick();
        idle();
        checks++; if (exe_valid_q !== 1'b1) begin errors++; $display("FAIL first_exe_valid got %b exp 1", exe_valid_q); end
        checks++; if (exe_cond_pass_q !== 1'b0) begin errors++; $display("FAIL first_exe_pass got %b exp 0", exe_cond_pass_q); end
    endtask

    // Full condition table against two flag settings loaded with count==0.
    task automatic test_cond_decode();
        logic [3:0]  flag_set [2];
        logic [15:0] exp_tab  [2];
        logic [15:0] row;
        flag_set[0] = 4'b0110; exp_tab[0] = 16'b1110_0110_1010_0101;
        flag_set[1] = 4'b1001; exp_tab[1] = 16'b1101_0110_0101_1010;
        for (int k = 0; k < 2; k++) begin
            idle();
            flag_we   = 1'b1;
            status_in = flag_set[k];
            tick();
            idle();
            checks++; if (status_q !== flag_set[k]) begin errors++; $display("FAIL load_flags got %b exp %b", status_q, flag_set[k]); end
            row = exp_tab[k];
            id_valid = 1'b1;
            for (int c = 0; c < 16; c++) begin
                id_cond = c[3:0];
                #1;
                checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL decode_stall cond %0d got %b exp 0", c, id_stall); end
                checks++; if (id_cond_pass !== row[c]) begin errors++; $display("FAIL decode flags %b cond %0d got %b exp %b", flag_set[k], c, id_cond_pass, row[c]); end
            end
            idle();
        end
        checks++; if (carry_q !== 1'b0) begin errors++; $display("FAIL carry_after_1001 got %b exp 0", carry_q); end
    endtask

    task automatic test_forwarding();
        issue_s_al();
        idle();
        id_valid  = 1'b1;
        id_cond   = 4'b0000;
        flag_we   = 1'b1;
        status_in = 4'b0100;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL fwd_stall got %b exp 0", id_stall); end
        checks++; if (id_cond_pass !== 1'b1) begin errors++; $display("FAIL fwd_pass got %b exp 1", id_cond_pass); end
        tick();
        idle();
        checks++; if (status_q !== 4'b0100) begin errors++; $display("FAIL fwd_status got %b exp 0100", status_q); end
        checks++; if (exe_cond_pass_q !== 1'b1) begin errors++; $display("FAIL fwd_exe_pass got %b exp 1", exe_cond_pass_q); end
        // count must now be 0: NE does not stall and reads Z=1
        id_valid = 1'b1;
        id_cond  = 4'b0001;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL fwd_count0_stall got %b exp 0", id_stall); end
        checks++; if (id_cond_pass !== 1'b0) begin errors++; $display("FAIL fwd_ne_pass got %b exp 0", id_cond_pass); end
        tick();
        idle();
    endtask

    task automatic test_hazard_stall();
        issue_s_al();
        issue_s_al();
        idle();
        id_valid = 1'b1;
        id_cond  = 4'b1011;
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL haz_c2_stall got %b exp 1", id_stall); end
        flag_we   = 1'b1;
        status_in = 4'b1000;
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL haz_c2_we_stall got %b exp 1", id_stall); end
        tick();
        checks++; if (exe_valid_q !== 1'b0) begin errors++; $display("FAIL haz_no_issue got %b exp 0", exe_valid_q); end
        flag_we = 1'b0;
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL haz_c1_stall got %b exp 1", id_stall); end
        tick();
        flag_we   = 1'b1;
        status_in = 4'b0001;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL haz_release got %b exp 0", id_stall); end
        checks++; if (id_cond_pass !== 1'b1) begin errors++; $display("FAIL haz_lt_pass got %b exp 1", id_cond_pass); end
        tick();
        idle();
        checks++; if (exe_valid_q !== 1'b1) begin errors++; $display("FAIL haz_exe_valid got %b exp 1", exe_valid_q); end
        checks++; if (exe_cond_pass_q !== 1'b1) begin errors++; $display("FAIL haz_exe_pass got %b exp 1", exe_cond_pass_q); end
        checks++; if (status_q !== 4'b0001) begin errors++; $display("FAIL haz_status got %b exp 0001", status_q); end
    endtask

    task automatic test_saturation();
        issue_s_al();
        issue_s_al();
        issue_s_al();
        idle();
        id_valid = 1'b1;
        id_s     = 1'b1;
        id_cond  = 4'b1110;
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL sat_stall got %b exp 1", id_stall); end
        flag_we = 1'b1;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL sat_we_stall got %b exp 0", id_stall); end
        tick();
        idle();
        checks++; if (exe_valid_q !== 1'b1) begin errors++; $display("FAIL sat_exe_valid got %b exp 1", exe_valid_q); end
        // still saturated at 3
        id_valid = 1'b1;
        id_s     = 1'b1;
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL sat_hold3 got %b exp 1", id_stall); end
        id_s = 1'b0;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL sat_al_nos got %b exp 0", id_stall); end
        // flush from count 3 while writing flags
        id_s      = 1'b1;
        flush     = 1'b1;
        flag_we   = 1'b1;
        status_in = 4'b1111;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL sat_flush_stall got %b exp 0", id_stall); end
        tick();
        idle();
        checks++; if (status_q !== 4'b1111) begin errors++; $display("FAIL sat_flush_status got %b exp 1111", status_q); end
        checks++; if (exe_valid_q !== 1'b0) begin errors++; $display("FAIL sat_flush_exe got %b exp 0", exe_valid_q); end
    endtask

    task automatic test_flush();
        issue_s_al();
        issue_s_al();
        idle();
        id_valid  = 1'b1;
        id_cond   = 4'b0000;
        flush     = 1'b1;
        flag_we   = 1'b1;
        status_in = 4'b0010;
        tick();
        idle();
        checks++; if (status_q !== 4'b0010) begin errors++; $display("FAIL flush_status got %b exp 0010", status_q); end
        checks++; if (carry_q !== 1'b1) begin errors++; $display("FAIL flush_carry got %b exp 1", carry_q); end
        checks++; if (exe_valid_q !== 1'b0) begin errors++; $display("FAIL flush_exe_valid got %b exp 0", exe_valid_q); end
        id_valid = 1'b1;
        id_cond  = 4'b0011;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL flush_count0 got %b exp 0", id_stall); end
        checks++; if (id_cond_pass !== 1'b0) begin errors++; $display("FAIL flush_cc_pass got %b exp 0", id_cond_pass); end
        tick();
        idle();
    endtask

    task automatic test_async_reset();
        issue_s_al();
        // S issue plus retirement with flag write keeps count at 1
        idle();
        id_valid  = 1'b1;
        id_s      = 1'b1;
        flag_we   = 1'b1;
        status_in = 4'b1001;
        tick();
        issue_s_al();
        idle();
        checks++; if (status_q !== 4'b1001) begin errors++; $display("FAIL ar_status_pre got %b exp 1001", status_q); end
        checks++; if (exe_valid_q !== 1'b1) begin errors++; $display("FAIL ar_exe_pre got %b exp 1", exe_valid_q); end
        id_valid = 1'b1;
        id_cond  = 4'b0000;
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL ar_c2_stall got %b exp 1", id_stall); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (status_q !== 4'b0000) begin errors++; $display("FAIL ar_status got %b exp 0000", status_q); end
        checks++; if (carry_q !== 1'b0) begin errors++; $display("FAIL ar_carry got %b exp 0", carry_q); end
        checks++; if (exe_valid_q !== 1'b0) begin errors++; $display("FAIL ar_exe_valid got %b exp 0", exe_valid_q); end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL ar_stall_release got %b exp 0", id_stall); end
        checks++; if (id_cond_pass !== 1'b0) begin errors++; $display("FAIL ar_eq_pass got %b exp 0", id_cond_pass); end
        #1;
        rst     = 1'b0;
        id_cond = 4'b0001;
        tick();
        idle();
        checks++; if (exe_valid_q !== 1'b1) begin errors++; $display("FAIL ar_post_exe_valid got %b exp 1", exe_valid_q); end
        checks++; if (exe_cond_pass_q !== 1'b1) begin errors++; $display("FAIL ar_post_exe_pass got %b exp 1", exe_cond_pass_q); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_cond_decode();
        test_forwarding();
        test_hazard_stall();
        test_saturation();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/flag_cond_unit.md
FLAG_COND_UNIT -- requirements
Module: flag_cond_unit

Interface
REQ-001 Parameter: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 id_valid  input  1  ID-stage instruction present.
REQ-005 id_cond  input  4  ARM condition field of ID instruction.
REQ-006 id_s  input  1  ID instruction will write flags (S bit).
REQ-007 flush  input  1  squash ID/EXE contents this cycle.
REQ-008 flag_we  input  1  EXE-stage ALU result writes flags this cycle.
REQ-009 status_in  input  4  ALU flags {N,Z,C,V}.
REQ-010 status_q  output  4  architectural flags {N,Z,C,V}.
REQ-011 carry_q  output  1  status_q[1]; drives ALU carry_in for ADC/SBC.
REQ-012 id_stall  output  1  combinational; hold ID instruction this cycle.
REQ-013 id_cond_pass  output  1  combinational condition result for ID instruction.
REQ-014 exe_valid_q  output  1  registered: an instruction issued into EXE.
REQ-015 exe_cond_pass_q  output  1  registered: issued instruction's condition passed.

Function
REQ-016 Condition decode SHALL be: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 and 1111 always true.
REQ-017 A 2-bit pending counter SHALL track issued, not-yet-written flag-setting instructions (range 0..3).
REQ-018 issue = id_valid & !id_stall & !flush.
REQ-019 Counter next = count + (issue & id_s) - (flag_we & count!=0); flush forces next = 0.
REQ-020 flag_we with count==0 SHALL leave count at 0 (no underflow) and still update status_q.
REQ-021 On flag_we, status_q SHALL load status_in at the clock edge, including in a flush cycle.
REQ-022 Flags used for evaluation: status_in when flag_we & count==1 (forwarding), else status_q.
REQ-023 needs_flags = id_cond not in {1110,1111}.
REQ-024 hazard = count>=2, or count==1 & !flag_we.
REQ-025 id_stall = id_valid & !flush & ((needs_flags & hazard) | (id_s & count==3 & !flag_we)).
REQ-026 id_cond_pass SHALL be valid only when id_valid & !id_stall; otherwise don't-care.
REQ-027 exe_valid_q <= issue; exe_cond_pass_q <= issue & id_cond_pass; one-cycle latency.
REQ-028 AL-condition instructions SHALL never stall on flags, only on counter saturation.
REQ-029 Simultaneous issue with id_s and flag_we SHALL leave count unchanged.
REQ-030 Squashed in-flight S instructions SHALL be kept off flag_we by the pipeline upstream; this block does not filter.

Reset
REQ-031 rst high SHALL immediately set status_q=0000, carry_q=0, count=0, exe_valid_q=0, exe_cond_pass_q=0.
REQ-032 During reset id_stall SHALL evaluate with count=0 (no flag stall); reset mid-stall releases the stall.
REQ-033 First rising edge after rst deasserts SHALL operate normally.

Verification
REQ-034 Reset, then id_valid=1, id_cond=0000, count=0 -> id_stall=0, id_cond_pass=0 (Z=0); next cycle exe_valid_q=1, exe_cond_pass_q=0.
REQ-035 Issue id_s=1 (count->1); next cycle id_cond=0000, flag_we=1, status_in=0100 -> no stall, id_cond_pass=1 (forwarded); status_q=0100 after edge, count=0.
REQ-036 count=2, id_cond=1011 -> id_stall=1 held until count reaches 1 with flag_we=1, then pass evaluates on status_in.
REQ-037 Three S issues with no flag_we (count=3), fourth id_s=1 id_cond=1110 -> id_stall=1; with flag_we=1 same cycle -> id_stall=0, count stays 3.
REQ-038 count=2, flush=1 with flag_we=1, status_in=0010 -> count=0, status_q=0010, carry_q=1, exe_valid_q=0 next cycle.
REQ-039 Assert rst asynchronously mid-cycle with count=2, status_q=1001 -> outputs zero before next clock edge.
